// File: rtl/ub_arbiter.sv
// Round-robin burst sequencer sharing the single-port unified buffer between FIFO and compute sides.
// Accesses are combinational from state; read valid lags ub_re by one cycle; a deasserted valid/ready stalls the beat.
module ub_arbiter #(
  parameter int BUFFER_SIZE  = 1024,
  parameter int ADDRESS_SIZE = $clog2(BUFFER_SIZE),
  parameter int LEN_SIZE     = ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_cmd_valid,
  output logic                    f_cmd_ready,
  input  logic                    f_cmd_write,
  input  logic [ADDRESS_SIZE-1:0] f_cmd_addr,
  input  logic [LEN_SIZE-1:0]     f_cmd_len,
  input  logic                    c_cmd_valid,
  output logic                    c_cmd_ready,
  input  logic                    c_cmd_write,
  input  logic [ADDRESS_SIZE-1:0] c_cmd_addr,
  input  logic [LEN_SIZE-1:0]     c_cmd_len,
  input  logic                    f_wdata_valid,
  output logic                    f_wdata_ready,
  input  logic                    c_wdata_valid,
  output logic                    c_wdata_ready,
  input  logic                    f_rdata_ready,
  output logic                    f_rdata_valid,
  input  logic                    c_rdata_ready,
  output logic                    c_rdata_valid,
  output logic                    f_done,
  output logic                    c_done,
  output logic                    ub_we,
  output logic                    ub_re,
  output logic                    ub_compute_en,
  output logic                    ub_fifo_en,
  output logic [ADDRESS_SIZE-1:0] ub_address
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    F_BURST = 2'd1,
    C_BURST = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    dir, dir_nxt;               // 1 = write burst
  logic [ADDRESS_SIZE-1:0] addr, addr_nxt;
  logic [LEN_SIZE-1:0]     remaining, remaining_nxt;
  logic                    last_grant, last_grant_nxt; // 1 = compute side
  logic                    f_rvld_q, c_rvld_q;
  logic                    grant_f, grant_c;
  logic                    f_own, c_own;
  logic                    beat;

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    addr_nxt       = addr;
    remaining_nxt  = remaining;
    last_grant_nxt = last_grant;
    f_cmd_ready    = 1'b0;
    c_cmd_ready    = 1'b0;
    f_wdata_ready  = 1'b0;
    c_wdata_ready  = 1'b0;
    f_done         = 1'b0;
    c_done         = 1'b0;
    ub_we          = 1'b0;
    ub_re          = 1'b0;
    ub_compute_en  = 1'b0;
    ub_fifo_en     = 1'b0;
    ub_address     = '0;
    beat           = 1'b0;
    f_own          = (state == F_BURST);
    c_own          = (state == C_BURST);
    // On a tie the side that did not win last time gets the buffer.
    grant_c        = c_cmd_valid && (!f_cmd_valid || !last_grant);
    grant_f        = f_cmd_valid && !grant_c;

    // Every output reads as zero while reset is held, so no handshake is lost to it.
    if (!rst) begin
      case (state)
        IDLE: begin
          f_cmd_ready = grant_f;
          c_cmd_ready = grant_c;
          if (grant_c) begin
            state_nxt      = C_BURST;
            dir_nxt        = c_cmd_write;
            addr_nxt       = c_cmd_addr;
            remaining_nxt  = c_cmd_len;
            last_grant_nxt = 1'b1;
          end else if (grant_f) begin
            state_nxt      = F_BURST;
            dir_nxt        = f_cmd_write;
            addr_nxt       = f_cmd_addr;
            remaining_nxt  = f_cmd_len;
            last_grant_nxt = 1'b0;
          end
        end
        F_BURST, C_BURST: begin
          ub_fifo_en    = f_own;
          ub_compute_en = c_own;
          ub_address    = addr;
          f_wdata_ready = f_own && dir;
          c_wdata_ready = c_own && dir;
          if (dir) beat = f_own ? f_wdata_valid : c_wdata_valid;
          else     beat = f_own ? f_rdata_ready : c_rdata_ready;
          ub_we = dir && beat;
          ub_re = !dir && beat;
          if (beat) begin
            addr_nxt      = addr + ADDRESS_SIZE'(1);
            remaining_nxt = remaining - LEN_SIZE'(1);
            if (remaining == '0) begin
              f_done    = f_own;
              c_done    = c_own;
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    f_rdata_valid = f_rvld_q && !rst;
    c_rdata_valid = c_rvld_q && !rst;
  end

  // Read-valid flags track the buffer's registered output, independent of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      last_grant <= 1'b0;
      f_rvld_q   <= 1'b0;
      c_rvld_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      addr       <= addr_nxt;
      remaining  <= remaining_nxt;
      last_grant <= last_grant_nxt;
      f_rvld_q   <= ub_re && f_own;
      c_rvld_q   <= ub_re && c_own;
    end
  end

endmodule
